// File: rtl/id_branch_stage.sv
// IF/ID pipeline register with decode-stage beq/bne/j resolution.
// A taken redirect squashes the wrong-path fetch with a single bubble.
module id_branch_stage #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc4,
  input  logic        stall,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc4,
  output logic        out_valid,
  output logic [31:0] beq,
  output logic        sel,
  output logic [15:0] redirects
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  state_t      r_state;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [15:0] r_redirects;

  logic [5:0]  w_opcode;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_target;
  logic        w_cond;
  logic        w_taken;

  assign w_opcode    = r_inst[31:26];
  assign w_br_target = r_pc4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_j_target  = {r_pc4[31:28], r_inst[25:0], 2'b00};

  always_comb begin
    w_cond   = 1'b0;
    w_target = w_br_target;
    case (w_opcode)
      OP_BEQ: w_cond = (rs_data == rt_data);
      OP_BNE: w_cond = (rs_data != rt_data);
      OP_J: begin
        w_cond   = 1'b1;
        w_target = w_j_target;
      end
      default: w_cond = 1'b0;
    endcase
  end

  // Bubbles and stalled cycles never redirect, whatever the opcode bits say.
  assign w_taken = r_valid & ~stall & (r_state == RUN) & w_cond;

  assign sel       = w_taken;
  assign beq       = w_taken ? w_target : 32'h0;
  assign out_inst  = r_inst;
  assign out_pc4   = r_pc4;
  assign out_valid = r_valid;
  assign redirects = r_redirects;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_inst      <= NOP;
      r_pc4       <= 32'h0;
      r_valid     <= 1'b0;
      r_redirects <= 16'h0;
    end else if (!stall) begin
      case (r_state)
        RUN: begin
          r_pc4 <= in_pc4;
          if (w_taken) begin
            r_inst      <= NOP;
            r_valid     <= 1'b0;
            r_redirects <= r_redirects + 16'h1;
            r_state     <= BUBBLE;
          end else begin
            r_inst  <= in_inst;
            r_valid <= 1'b1;
          end
        end
        BUBBLE: begin
          r_inst  <= in_inst;
          r_pc4   <= in_pc4;
          r_valid <= 1'b1;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_branch_stage.sv
// Directed bench for id_branch_stage: reset, beq/bne/j resolution, stall,
// back-to-back squash, counter wrap and asynchronous reset.
module tb_id_branch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] in_inst;
  logic [31:0] in_pc4;
  logic        stall;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic        out_valid;
  logic [31:0] beq;
  logic        sel;
  logic [15:0] redirects;

  int n_pass;
  int n_total;

  id_branch_stage #(.NOP(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .in_inst(in_inst), .in_pc4(in_pc4),
    .stall(stall), .rs_data(rs_data), .rt_data(rt_data),
    .out_inst(out_inst), .out_pc4(out_pc4), .out_valid(out_valid),
    .beq(beq), .sel(sel), .redirects(redirects)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_inst = $urandom; in_pc4 = $urandom; rs_data = $urandom; rt_data = rs_data;
      tick();
    end
    n_total++; if (out_inst !== 32'h0) $display("FAIL reset_inst got %h want 0", out_inst); else n_pass++;
    n_total++; if (out_pc4 !== 32'h0) $display("FAIL reset_pc4 got %h want 0", out_pc4); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (sel !== 1'b0) $display("FAIL reset_sel got %b want 0", sel); else n_pass++;
    n_total++; if (beq !== 32'h0) $display("FAIL reset_beq got %h want 0", beq); else n_pass++;
    n_total++; if (redirects !== 16'h0) $display("FAIL reset_cnt got %h want 0", redirects); else n_pass++;
    reset = 1'b1; in_inst = 32'h2008_0005; in_pc4 = 32'h4; rs_data = 0; rt_data = 0;
    tick();
    n_total++; if (out_inst !== 32'h2008_0005) $display("FAIL rel_inst got %h want 20080005", out_inst); else n_pass++;
    n_total++; if (out_pc4 !== 32'h4) $display("FAIL rel_pc4 got %h want 4", out_pc4); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL rel_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (sel !== 1'b0) $display("FAIL rel_sel got %b want 0", sel); else n_pass++;
  endtask

  task automatic test_beq_taken();
    in_inst = 32'h1109_0003; in_pc4 = 32'h10;
    tick();
    rs_data = 7; rt_data = 7; #1;
    n_total++; if (sel !== 1'b1) $display("FAIL beq_sel got %b want 1", sel); else n_pass++;
    n_total++; if (beq !== 32'h1C) $display("FAIL beq_target got %h want 1c", beq); else n_pass++;
    in_inst = 32'h2000_0001; in_pc4 = 32'h14;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL beq_bubble_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_inst !== 32'h0) $display("FAIL beq_bubble_inst got %h want 0", out_inst); else n_pass++;
    n_total++; if (redirects !== 16'd1) $display("FAIL beq_cnt got %0d want 1", redirects); else n_pass++;
    n_total++; if (sel !== 1'b0) $display("FAIL beq_bubble_sel got %b want 0", sel); else n_pass++;
    in_inst = 32'h2000_0002; in_pc4 = 32'h20;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL beq_resume_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_inst !== 32'h2000_0002) $display("FAIL beq_resume_inst got %h want 20000002", out_inst); else n_pass++;
    n_total++; if (out_pc4 !== 32'h20) $display("FAIL beq_resume_pc4 got %h want 20", out_pc4); else n_pass++;
  endtask

  task automatic test_bne_wrap();
    in_inst = 32'h1509_FFFF; in_pc4 = 32'h0;
    tick();
    rs_data = 1; rt_data = 2; #1;
    n_total++; if (beq !== 32'hFFFF_FFFC) $display("FAIL bne_target got %h want fffffffc", beq); else n_pass++;
    n_total++; if (sel !== 1'b1) $display("FAIL bne_sel got %b want 1", sel); else n_pass++;
    rt_data = 1; #1;
    n_total++; if (sel !== 1'b0) $display("FAIL bne_eq_sel got %b want 0", sel); else n_pass++;
    n_total++; if (beq !== 32'h0) $display("FAIL bne_eq_beq got %h want 0", beq); else n_pass++;
    in_inst = 32'h2000_0003; in_pc4 = 32'h4;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL bne_nobubble_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_inst !== 32'h2000_0003) $display("FAIL bne_next_inst got %h want 20000003", out_inst); else n_pass++;
    n_total++; if (redirects !== 16'd1) $display("FAIL bne_cnt got %0d want 1", redirects); else n_pass++;
  endtask

  task automatic test_jump();
    in_inst = 32'h0800_0040; in_pc4 = 32'h4000_0008;
    tick();
    n_total++; if (beq !== 32'h4000_0100) $display("FAIL j_target got %h want 40000100", beq); else n_pass++;
    n_total++; if (sel !== 1'b1) $display("FAIL j_sel got %b want 1", sel); else n_pass++;
    in_inst = 32'h2000_0004; in_pc4 = 32'h4000_000C;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL j_bubble_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (redirects !== 16'd2) $display("FAIL j_cnt got %0d want 2", redirects); else n_pass++;
    in_inst = 32'h2000_0005; in_pc4 = 32'h4000_0104;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL j_resume_valid got %b want 1", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    in_inst = 32'h1109_0003; in_pc4 = 32'h10; rs_data = 7; rt_data = 7;
    tick();
    stall = 1'b1; #1;
    n_total++; if (sel !== 1'b0) $display("FAIL stall_sel got %b want 0", sel); else n_pass++;
    n_total++; if (beq !== 32'h0) $display("FAIL stall_beq got %h want 0", beq); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_inst = $urandom; in_pc4 = $urandom;
      tick();
      n_total++; if (out_inst !== 32'h1109_0003) $display("FAIL stall_hold_inst got %h want 11090003", out_inst); else n_pass++;
      n_total++; if (out_pc4 !== 32'h10) $display("FAIL stall_hold_pc4 got %h want 10", out_pc4); else n_pass++;
      n_total++; if (sel !== 1'b0) $display("FAIL stall_hold_sel got %b want 0", sel); else n_pass++;
      n_total++; if (redirects !== 16'd2) $display("FAIL stall_hold_cnt got %0d want 2", redirects); else n_pass++;
    end
    stall = 1'b0; #1;
    n_total++; if (sel !== 1'b1) $display("FAIL unstall_sel got %b want 1", sel); else n_pass++;
    n_total++; if (beq !== 32'h1C) $display("FAIL unstall_beq got %h want 1c", beq); else n_pass++;
    in_inst = 32'h2000_0006; in_pc4 = 32'h14;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL unstall_bubble got %b want 0", out_valid); else n_pass++;
    n_total++; if (redirects !== 16'd3) $display("FAIL unstall_cnt got %0d want 3", redirects); else n_pass++;
    in_inst = 32'h2000_0007; in_pc4 = 32'h20;
    tick();
  endtask

  task automatic test_back_to_back();
    in_inst = 32'h1109_0003; in_pc4 = 32'h10; rs_data = 7; rt_data = 7;
    tick();
    n_total++; if (sel !== 1'b1) $display("FAIL b2b_first_sel got %b want 1", sel); else n_pass++;
    in_inst = 32'h1109_0010; in_pc4 = 32'h14;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_squash_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_inst !== 32'h0) $display("FAIL b2b_squash_inst got %h want 0", out_inst); else n_pass++;
    n_total++; if (sel !== 1'b0) $display("FAIL b2b_squash_sel got %b want 0", sel); else n_pass++;
    n_total++; if (redirects !== 16'd4) $display("FAIL b2b_cnt1 got %0d want 4", redirects); else n_pass++;
    in_inst = 32'h1109_0002; in_pc4 = 32'h20;
    tick();
    n_total++; if (sel !== 1'b1) $display("FAIL b2b_target_sel got %b want 1", sel); else n_pass++;
    n_total++; if (beq !== 32'h28) $display("FAIL b2b_target_beq got %h want 28", beq); else n_pass++;
    in_inst = 32'h2000_0008; in_pc4 = 32'h24;
    tick();
    n_total++; if (redirects !== 16'd5) $display("FAIL b2b_cnt2 got %0d want 5", redirects); else n_pass++;
    in_inst = 32'h2000_0009; in_pc4 = 32'h2C;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_resume_valid got %b want 1", out_valid); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    in_inst = 32'h1109_0003; in_pc4 = 32'h10; rs_data = 5; rt_data = 5;
    tick();
    dut.r_redirects = 16'hFFFF; #1;
    n_total++; if (redirects !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", redirects); else n_pass++;
    n_total++; if (sel !== 1'b1) $display("FAIL wrap_sel got %b want 1", sel); else n_pass++;
    in_inst = 32'h1109_0003; in_pc4 = 32'h14;
    tick();
    n_total++; if (redirects !== 16'h0000) $display("FAIL wrap_cnt got %h want 0000", redirects); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL wrap_bubble got %b want 0", out_valid); else n_pass++;
    in_inst = 32'h1109_0003; in_pc4 = 32'h40;
    tick();
    n_total++; if (sel !== 1'b1) $display("FAIL arst_pre_sel got %b want 1", sel); else n_pass++;
    n_total++; if (beq !== 32'h4C) $display("FAIL arst_pre_beq got %h want 4c", beq); else n_pass++;
    #1 reset = 1'b0; #1;
    n_total++; if (sel !== 1'b0) $display("FAIL arst_sel got %b want 0", sel); else n_pass++;
    n_total++; if (beq !== 32'h0) $display("FAIL arst_beq got %h want 0", beq); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_inst !== 32'h0) $display("FAIL arst_inst got %h want 0", out_inst); else n_pass++;
    n_total++; if (redirects !== 16'h0) $display("FAIL arst_cnt got %h want 0", redirects); else n_pass++;
    reset = 1'b1; in_inst = 32'h2008_0005; in_pc4 = 32'h4;
    tick();
    n_total++; if (out_inst !== 32'h2008_0005) $display("FAIL arst_rel_inst got %h want 20080005", out_inst); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL arst_rel_valid got %b want 1", out_valid); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; stall = 1'b0; in_inst = 0; in_pc4 = 0; rs_data = 0; rt_data = 0;
    test_reset();
    test_beq_taken();
    test_bne_wrap();
    test_jump();
    test_stall();
    test_back_to_back();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
